// File: rtl/tl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tl_pkg : shared mode/phase encodings and lamp patterns for the traffic light
// Revision: 1.0
// ---------------------------------------------------------------------------
package tl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_RUN   = 2'd1,
    MODE_SET_G = 2'd2,
    MODE_SET_Y = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    PH_NS_G = 2'd0,
    PH_NS_Y = 2'd1,
    PH_EW_G = 2'd2,
    PH_EW_Y = 2'd3
  } phase_e;

  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_R   = 3'b100;

  function automatic logic is_green(input phase_e p);
    return (p == PH_NS_G) || (p == PH_EW_G);
  endfunction

  function automatic logic [2:0] lamp_ns(input phase_e p);
    case (p)
      PH_NS_G: return LAMP_G;
      PH_NS_Y: return LAMP_Y;
      default: return LAMP_R;
    endcase
  endfunction

  function automatic logic [2:0] lamp_ew(input phase_e p);
    case (p)
      PH_EW_G: return LAMP_G;
      PH_EW_Y: return LAMP_Y;
      default: return LAMP_R;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/tl_tick_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tl_tick_gen : free-running prescaler giving a 1-cycle tick and a blink toggle
// Revision: 1.0
// ---------------------------------------------------------------------------
module tl_tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o,
  output logic blink_o
);

  localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blink_q, blink_d;

  assign tick_o  = (cnt_q == CNT_LAST);
  assign blink_o = blink_q;

  always_comb begin
    cnt_d   = tick_o ? '0 : cnt_q + 1'b1;
    blink_d = blink_q ^ tick_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tl_mode_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tl_mode_ctrl : mode controller / phase sequencer for a two-way traffic light.
// Optional pedestrian request logic enabled by macro TL_PED_REQ_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tl_mode_ctrl
  import tl_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int DUR_W      = 8,
  parameter int GREEN_DEF  = 25,
  parameter int YELLOW_DEF = 5,
  parameter int GREEN_MAX  = 99,
  parameter int YELLOW_MAX = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             online_btn,
  input  logic             set_btn,
  input  logic             inc_btn,
`ifdef TL_PED_REQ_EN
  input  logic             ped_req,
  output logic             ped_wait,
`endif
  output logic             online,
  output logic             set,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic [DUR_W-1:0] remain,
  output logic [1:0]       phase
);

  localparam logic [DUR_W-1:0] GREEN_RST  = DUR_W'(GREEN_DEF);
  localparam logic [DUR_W-1:0] YELLOW_RST = DUR_W'(YELLOW_DEF);
  localparam logic [DUR_W-1:0] GREEN_TOP  = DUR_W'(GREEN_MAX);
  localparam logic [DUR_W-1:0] YELLOW_TOP = DUR_W'(YELLOW_MAX);
  localparam logic [DUR_W-1:0] ONE        = DUR_W'(1);

  logic tick, blink, blink_d;

  tl_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .tick_o  (tick),
    .blink_o (blink)
  );

  mode_e            mode_q, mode_d;
  phase_e           phase_q, phase_d;
  logic [DUR_W-1:0] remain_q, remain_d;
  logic [DUR_W-1:0] green_q, green_d;
  logic [DUR_W-1:0] yellow_q, yellow_d;
  logic [2:0]       ns_q, ns_d, ew_q, ew_d;
  logic             online_q, online_d, set_q, set_d;

  // online_btn outranks the others even in modes where it has no effect
  logic set_act, inc_act;
  assign set_act = set_btn & ~online_btn;
  assign inc_act = inc_btn & ~online_btn & ~set_btn;

`ifdef TL_PED_REQ_EN
  logic ped_wait_q, ped_wait_d;
`endif

  always_comb begin
    mode_d   = mode_q;
    phase_d  = phase_q;
    remain_d = remain_q;
    green_d  = green_q;
    yellow_d = yellow_q;

    case (mode_q)
      MODE_OFF: begin
        if (online_btn) begin
          mode_d   = MODE_RUN;
          phase_d  = PH_NS_G;
          remain_d = green_q;
        end else if (set_act) begin
          mode_d = MODE_SET_G;
        end
      end
      MODE_RUN: begin
        if (online_btn) begin
          mode_d  = MODE_OFF;
          phase_d = PH_NS_G;
        end else if (tick) begin
          if (remain_q > ONE) begin
            remain_d = remain_q - 1'b1;
          end else begin
            phase_d  = phase_e'(phase_q + 2'd1);
            remain_d = is_green(phase_d) ? green_q : yellow_q;
          end
        end
      end
      MODE_SET_G: begin
        if (set_act) begin
          mode_d = MODE_SET_Y;
        end else if (inc_act) begin
          green_d = (green_q == GREEN_TOP) ? ONE : green_q + 1'b1;
        end
      end
      MODE_SET_Y: begin
        if (set_act) begin
          mode_d = MODE_OFF;
        end else if (inc_act) begin
          yellow_d = (yellow_q == YELLOW_TOP) ? ONE : yellow_q + 1'b1;
        end
      end
      default: mode_d = MODE_OFF;
    endcase

`ifdef TL_PED_REQ_EN
    ped_wait_d = ped_wait_q;
    if ((mode_d != MODE_RUN) || !is_green(phase_d)) begin
      ped_wait_d = 1'b0;
    end else if ((mode_q == MODE_RUN) && ped_req && !online_btn && (phase_d == phase_q)) begin
      ped_wait_d = 1'b1;
      if (remain_d > DUR_W'(5)) remain_d = DUR_W'(5);
    end
`endif

    // Outside RUN the display shows the duration being edited, or nothing
    case (mode_d)
      MODE_OFF:   remain_d = '0;
      MODE_SET_G: remain_d = green_d;
      MODE_SET_Y: remain_d = yellow_d;
      default:    ;
    endcase

    blink_d  = blink ^ tick;
    online_d = (mode_d == MODE_RUN);
    set_d    = (mode_d == MODE_SET_G) || (mode_d == MODE_SET_Y);

    case (mode_d)
      MODE_OFF: begin
        ns_d = {1'b0, blink_d, 1'b0};
        ew_d = {1'b0, blink_d, 1'b0};
      end
      MODE_RUN: begin
        ns_d = lamp_ns(phase_d);
        ew_d = lamp_ew(phase_d);
      end
      MODE_SET_G: begin
        ns_d = LAMP_G;
        ew_d = LAMP_G;
      end
      default: begin
        ns_d = LAMP_Y;
        ew_d = LAMP_Y;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= MODE_OFF;
      phase_q  <= PH_NS_G;
      remain_q <= '0;
      green_q  <= GREEN_RST;
      yellow_q <= YELLOW_RST;
      ns_q     <= LAMP_OFF;
      ew_q     <= LAMP_OFF;
      online_q <= 1'b0;
      set_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      phase_q  <= phase_d;
      remain_q <= remain_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      ns_q     <= ns_d;
      ew_q     <= ew_d;
      online_q <= online_d;
      set_q    <= set_d;
    end
  end

`ifdef TL_PED_REQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ped_wait_q <= 1'b0;
    else     ped_wait_q <= ped_wait_d;
  end
  assign ped_wait = ped_wait_q;
`endif

  assign online   = online_q;
  assign set      = set_q;
  assign ns_light = ns_q;
  assign ew_light = ew_q;
  assign remain   = remain_q;
  assign phase    = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_tl_mode_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tl_mode_ctrl : self-checking bench with a behavioural traffic-light model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_tl_mode_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int DUR_W      = 8;
  localparam int GREEN_DEF  = 3;
  localparam int YELLOW_DEF = 2;
  localparam int GREEN_MAX  = 6;
  localparam int YELLOW_MAX = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             online_btn, set_btn, inc_btn;
  logic             online, set;
  logic [2:0]       ns_light, ew_light;
  logic [DUR_W-1:0] remain;
  logic [1:0]       phase;
`ifdef TL_PED_REQ_EN
  logic             ped_req = 1'b0;
  logic             ped_wait;
`endif

  always #5 clk = ~clk;

  tl_mode_ctrl #(
    .TICK_DIV(TICK_DIV), .DUR_W(DUR_W), .GREEN_DEF(GREEN_DEF),
    .YELLOW_DEF(YELLOW_DEF), .GREEN_MAX(GREEN_MAX), .YELLOW_MAX(YELLOW_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .online_btn (online_btn),
    .set_btn    (set_btn),
    .inc_btn    (inc_btn),
`ifdef TL_PED_REQ_EN
    .ped_req    (ped_req),
    .ped_wait   (ped_wait),
`endif
    .online     (online),
    .set        (set),
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .remain     (remain),
    .phase      (phase)
  );

  int checks = 0;
  int errors = 0;

  // Model: 0=OFF 1=RUN 2=SET_G 3=SET_Y; remain tracked only while running
  int m_mode, m_phase, m_remain, m_green, m_yellow, m_cycles, m_blink;
  int run_ns[4] = '{1, 2, 4, 4};
  int run_ew[4] = '{4, 4, 1, 2};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_phase = 0; m_remain = 0;
    m_green = GREEN_DEF; m_yellow = YELLOW_DEF;
    m_cycles = 0; m_blink = 0;
  endfunction

  function automatic void model_step(input bit o, input bit s, input bit i);
    bit tick;
    tick = ((m_cycles % TICK_DIV) == TICK_DIV - 1);
    m_cycles++;
    case (m_mode)
      0: if (o) begin m_mode = 1; m_phase = 0; m_remain = m_green; end
         else if (s) m_mode = 2;
      1: if (o) begin m_mode = 0; m_phase = 0; m_remain = 0; end
         else if (tick) begin
           if (m_remain > 1) m_remain--;
           else begin
             m_phase  = (m_phase + 1) % 4;
             m_remain = (m_phase % 2 == 0) ? m_green : m_yellow;
           end
         end
      2: if (!o) begin
           if (s) m_mode = 3;
           else if (i) m_green = (m_green == GREEN_MAX) ? 1 : m_green + 1;
         end
      default: if (!o) begin
           if (s) m_mode = 0;
           else if (i) m_yellow = (m_yellow == YELLOW_MAX) ? 1 : m_yellow + 1;
         end
    endcase
    if (tick) m_blink = 1 - m_blink;
  endfunction

  task automatic check_all();
    int e_rem, e_ns, e_ew;
    case (m_mode)
      0: begin e_rem = 0; e_ns = 2 * m_blink; e_ew = 2 * m_blink; end
      1: begin e_rem = m_remain; e_ns = run_ns[m_phase]; e_ew = run_ew[m_phase]; end
      2: begin e_rem = m_green; e_ns = 1; e_ew = 1; end
      default: begin e_rem = m_yellow; e_ns = 2; e_ew = 2; end
    endcase
    chk("online", int'(online), int'(m_mode == 1));
    chk("set", int'(set), int'(m_mode >= 2));
    chk("remain", int'(remain), e_rem);
    chk("ns_light", int'(ns_light), e_ns);
    chk("ew_light", int'(ew_light), e_ew);
    chk("phase", int'(phase), m_phase);
`ifdef TL_PED_REQ_EN
    chk("ped_wait", int'(ped_wait), 0);
`endif
  endtask

  task automatic step(input bit o, input bit s, input bit i);
    online_btn = o; set_btn = s; inc_btn = i;
    @(posedge clk);
    model_step(o, s, i);
    #1;
    online_btn = 1'b0; set_btn = 1'b0; inc_btn = 1'b0;
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int seq_ph[11] = '{0, 0, 0, 1, 1, 2, 2, 2, 3, 3, 0};
  int seq_rm[11] = '{3, 2, 1, 2, 1, 3, 2, 1, 2, 1, 3};

  initial begin
    int idx, prev_ph, prev_rm, guard;
    rst = 1'b1; online_btn = 1'b0; set_btn = 1'b0; inc_btn = 1'b0;
    model_reset();
    #12;
    chk("rst_online", int'(online), 0);
    chk("rst_remain", int'(remain), 0);
    chk("rst_ns", int'(ns_light), 0);
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Idle in OFF: flashing yellow toggles every TICK_DIV cycles
    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 0);
      if (k == 4 || k == 12) chk("off_blink_on", int'(ns_light), 3'b010);
      if (k == 8) chk("off_blink_off", int'(ew_light), 3'b000);
    end

    // RUN phase/remain sequence with GREEN_DEF=3, YELLOW_DEF=2
    step(1, 0, 0);
    chk("run_entry_remain", int'(remain), 3);
    chk("run_entry_ns", int'(ns_light), 3'b001);
    chk("run_entry_ew", int'(ew_light), 3'b100);
    idx = 1; prev_ph = int'(phase); prev_rm = int'(remain); guard = 0;
    while (idx < 11 && guard < 80) begin
      step(0, 0, 0);
      guard++;
      if (int'(phase) != prev_ph || int'(remain) != prev_rm) begin
        chk("seq_phase", int'(phase), seq_ph[idx]);
        chk("seq_remain", int'(remain), seq_rm[idx]);
        prev_ph = int'(phase); prev_rm = int'(remain); idx++;
      end
    end
    if (idx < 11) chk("seq_timeout", idx, 11);

    // Editing durations
    step(1, 0, 0);
    chk("off_remain", int'(remain), 0);
    step(0, 1, 0);
    chk("setg_set", int'(set), 1);
    chk("setg_remain", int'(remain), 3);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("setg_inc2", int'(remain), 5);
    step(0, 1, 0);
    chk("sety_remain", int'(remain), 2);
    for (int k = 0; k < 8; k++) step(0, 0, 1);
    chk("sety_wrap", int'(remain), 1);
    step(0, 1, 0);
    chk("back_off_set", int'(set), 0);
    step(1, 0, 0);
    chk("run_new_green", int'(remain), 5);

    // Async reset while in EW_G
    guard = 0;
    while (int'(phase) != 2 && guard < 100) begin step(0, 0, 0); guard++; end
    chk("reach_ew_g", int'(phase), 2);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_online", int'(online), 0);
    chk("arst_phase", int'(phase), 0);
    chk("arst_remain", int'(remain), 0);
    chk("arst_ew", int'(ew_light), 0);
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 0);
    chk("arst_green_def", int'(remain), GREEN_DEF);
    step(0, 1, 0);
    chk("arst_yellow_def", int'(remain), YELLOW_DEF);
    step(0, 1, 0);

    // Simultaneous buttons: online wins in OFF; set ignored in RUN
    step(1, 1, 0);
    chk("prio_online", int'(online), 1);
    chk("prio_set", int'(set), 0);
    step(0, 1, 1);
    chk("run_ignore_set", int'(set), 0);
    step(1, 0, 0);

    // Random stimulus against the model
    for (int k = 0; k < 2000; k++) begin
      step($urandom_range(0, 24) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
